// File: rtl/fft_pkg.sv
// Shared types, constants and fixed-point helpers for the radix-2 FFT datapath.
package fft_pkg;

    localparam int DW     = 16;
    localparam int TW_ONE = 16384;
    localparam int TWF    = 14;
    localparam int FFT_N  = 256;
    localparam int IDXW   = 8;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        if (v < lo)
            return lo;
        return v;
    endfunction

    // Round-half-up then arithmetic shift right by sh.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        if (sh <= 0)
            return v;
        return (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/fft_bfly_r2_cmul.sv
// bfly_cmul: registered B*W product stage plus rounded combinational recombination.
// Define BFLY_IFFT_EN to conjugate the twiddle for the inverse butterfly.
module bfly_cmul #(
    parameter int DW  = 16,
    parameter int TWW = 16,
    parameter int TWF = 14,
    parameter int OW  = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic signed [DW-1:0]  i_b_re,
    input  logic signed [DW-1:0]  i_b_im,
    input  logic signed [TWW-1:0] i_w_re,
    input  logic signed [TWW-1:0] i_w_im,
    output logic signed [OW-1:0]  o_t_re,
    output logic signed [OW-1:0]  o_t_im
);
    import fft_pkg::*;

    // One extra twiddle bit so that negating -1.0 stays representable.
    localparam int WW = TWW + 1;
    localparam int PW = DW + WW;
    localparam int SW = PW + 1;

    logic signed [WW-1:0] w_re;
    logic signed [WW-1:0] w_im;

    assign w_re = {i_w_re[TWW-1], i_w_re};
`ifdef BFLY_IFFT_EN
    assign w_im = -{i_w_im[TWW-1], i_w_im};
`else
    assign w_im = {i_w_im[TWW-1], i_w_im};
`endif

    logic signed [PW-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PW-1:0] rr_q, ii_q, ri_q, ir_q;

    assign rr_d = PW'(i_b_re) * PW'(w_re);
    assign ii_d = PW'(i_b_im) * PW'(w_im);
    assign ri_d = PW'(i_b_re) * PW'(w_im);
    assign ir_d = PW'(i_b_im) * PW'(w_re);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else if (i_en) begin
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
            ir_q <= ir_d;
        end
    end

    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;

    // Full-precision sums feed the rounder; nothing is dropped before the shift.
    assign sum_re = SW'(rr_q) - SW'(ii_q);
    assign sum_im = SW'(ri_q) + SW'(ir_q);

    assign o_t_re = OW'(round_shift(64'(sum_re), TWF));
    assign o_t_im = OW'(round_shift(64'(sum_im), TWF));

endmodule

// File: rtl/fft_bfly_r2.sv
// fft_bfly_r2: 3-stage radix-2 DIT butterfly X = A + B*W, Y = A - B*W with stall handshake.
// Define BFLY_IFFT_EN for the inverse (conjugate-twiddle) butterfly. DW must equal fft_pkg::DW.
module fft_bfly_r2 #(
    parameter int DW    = fft_pkg::DW,
    parameter int TWW   = 16,
    parameter int TWF   = fft_pkg::TWF,
    parameter int IDXW  = fft_pkg::IDXW,
    parameter int SCALE = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic signed [DW-1:0]   i_a_re,
    input  logic signed [DW-1:0]   i_a_im,
    input  logic signed [DW-1:0]   i_b_re,
    input  logic signed [DW-1:0]   i_b_im,
    input  logic [IDXW-1:0]        i_k,
    output logic [IDXW-1:0]        o_tw_n,
    input  logic signed [TWW-1:0]  i_tw_re,
    input  logic signed [TWW-1:0]  i_tw_im,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic signed [DW-1:0]   o_x_re,
    output logic signed [DW-1:0]   o_x_im,
    output logic signed [DW-1:0]   o_y_re,
    output logic signed [DW-1:0]   o_y_im
);
    import fft_pkg::*;

    localparam int XW = DW + 4;

    logic            en;
    logic            v0_q, v1_q, v2_q;
    cplx_t           a0_q, a1_q, b0_q;
    logic [IDXW-1:0] k0_q;

    logic signed [XW-1:0] t_re, t_im;
    logic signed [DW-1:0] x_re_d, x_im_d, y_re_d, y_im_d;
    logic signed [DW-1:0] x_re_q, x_im_q, y_re_q, y_im_q;

    // A single enable freezes the whole pipe while the output slot is full and not taken.
    assign en      = !v2_q || i_ready;
    assign o_ready = en;
    assign o_valid = v2_q;
    assign o_tw_n  = k0_q;
    assign o_x_re  = x_re_q;
    assign o_x_im  = x_im_q;
    assign o_y_re  = y_re_q;
    assign o_y_im  = y_im_q;

    bfly_cmul #(
        .DW  (DW),
        .TWW (TWW),
        .TWF (TWF),
        .OW  (XW)
    ) u_cmul (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (en),
        .i_b_re (b0_q.re),
        .i_b_im (b0_q.im),
        .i_w_re (i_tw_re),
        .i_w_im (i_tw_im),
        .o_t_re (t_re),
        .o_t_im (t_im)
    );

    function automatic logic signed [DW-1:0] post(input logic signed [XW-1:0] v);
        logic signed [63:0] w;
        w = 64'(v);
        if (SCALE != 0)
            w = (w + 64'sd1) >>> 1;
        return DW'(sat(w, DW));
    endfunction

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        x_re_d = post(XW'(a1_q.re) + t_re);
        x_im_d = post(XW'(a1_q.im) + t_im);
        y_re_d = post(XW'(a1_q.re) - t_re);
        y_im_d = post(XW'(a1_q.im) - t_im);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v0_q   <= 1'b0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            a0_q   <= '0;
            a1_q   <= '0;
            b0_q   <= '0;
            k0_q   <= '0;
            x_re_q <= '0;
            x_im_q <= '0;
            y_re_q <= '0;
            y_im_q <= '0;
        end else if (en) begin
            v0_q   <= i_valid;
            a0_q   <= '{re: i_a_re, im: i_a_im};
            b0_q   <= '{re: i_b_re, im: i_b_im};
            k0_q   <= i_k;
            v1_q   <= v0_q;
            a1_q   <= a0_q;
            v2_q   <= v1_q;
            x_re_q <= x_re_d;
            x_im_q <= x_im_d;
            y_re_q <= y_re_d;
            y_im_q <= y_im_d;
        end
    end

endmodule
